carfield_domain_sequencer: RTL and testbench
============================================

// Module: carfield_domain_sequencer
// PURPOSE
// Per-domain clock-gate / reset / isolation sequencer for the NumDomains clock-gateable subdomains
// (periph, safety island, security island, integer cluster, FP cluster, L2).
// Sits between the CarRegs enable register and the domain clock gates and reset synchronisers.
// Turns a level enable request into a glitch-free sequence: power-up is clk on, then reset release;
// power-down is isolate, drain, reset, then clk off.
// domain_clk_en_o and domain_rsts_n_o feed the debug-signal struct fields domain_clk and domain_rsts_n.
// PARAMETERS
// NumDomains      6    number of independent domains; bit index = domain index (PeriphDomainIdx=0 .. L2DomainIdx=5)
// ClkSettleCycles 4    cycles clock runs with reset held before release (>=1)
// RstCycles       8    cycles reset is held with clock running before gating (>=1)
// TimeoutCycles   1024 isolation-ack timeout, used only with the macro (>=2)
// PORTS
// clk_i            in  1          system clock
// rst_ni           in  1          async active-low reset
// en_req_i         in  NumDomains desired domain state (1 = on), level, from CarRegs
// iso_ack_i        in  NumDomains domain idle/isolated: no outstanding AXI txns
// domain_clk_en_o  out NumDomains clock-gate enable per domain
// domain_rsts_n_o  out NumDomains active-low domain reset
// domain_iso_o     out NumDomains isolation request to domain AXI boundary (1 = isolated)
// domain_on_o      out NumDomains status: domain in RUN
// busy_o           out NumDomains status: sequence in progress
// timeout_o        out NumDomains sticky isolation timeout flag (tied 0 without the macro)
// BEHAVIOUR
// - Clock is clk_i; reset is rst_ni, asynchronous and active-low.
// - Domains are fully independent: one FSM plus one counter per domain.
//   Simultaneous events on different domains never interact.
// - All outputs are driven directly from flops (no decode glitches on clk_en / rsts_n).
// - Reset (async, any time, including mid-sequence): every FSM goes to OFF and counters to 0.
//   Outputs: clk_en=0, rsts_n=0, iso=1, on=0, busy=0, timeout=0.
// - States and outputs, listed as {clk_en, rsts_n, iso, on, busy}:
//   OFF     {0,0,1,0,0}  en_req=1 -> CLK_ON, cnt<=0
//   CLK_ON  {1,0,1,0,1}  cnt++; cnt==ClkSettleCycles-1 -> RUN
//   RUN     {1,1,0,1,0}  en_req=0 -> ISOLATE, cnt<=0
//   ISOLATE {1,1,1,0,1}  iso_ack=1 -> RST, cnt<=0
//   RST     {1,0,1,0,1}  cnt++; cnt==RstCycles-1 -> OFF
// - en_req_i is sampled only in OFF and RUN; sequences are non-abortable.
//   Toggling en_req during CLK_ON/ISOLATE/RST takes effect only after the sequence completes.
// - Latency, power-up:
//   en_req seen high at edge t -> clk_en high after edge t;
//   rsts_n/on high after edge t+ClkSettleCycles.
// - Latency, power-down (iso_ack already 1):
//   iso high after edge t; rsts_n low after edge t+1; clk_en low after edge t+1+RstCycles.
// - iso_ack_i is ignored outside ISOLATE.
//   An ack already high on entry to ISOLATE advances on the next edge.
// - Counter width is $clog2(max(ClkSettleCycles,RstCycles,TimeoutCycles))+1.
//   The counter is never allowed to wrap.
// CONFIGURATION
// CARFIELD_DOMAIN_SEQ_TIMEOUT_EN defined:
// - The ISOLATE state also counts cycles.
// - cnt==TimeoutCycles-1 without iso_ack -> RST (forced reset) and sets timeout_o[d].
// - timeout_o[d] is cleared on the next entry to RUN.
// - An ack on the same cycle as the timeout wins: no flag is set.
// Not defined:
// - ISOLATE waits indefinitely for iso_ack_i.
// - timeout_o is constant 0 and no timeout counter logic is synthesised.
// TESTING
// 1. Reset, then en_req=6'b000001 -> clk_en[0] rises 1 cycle later; rsts_n[0] rises 4 cycles later; on[0]=1; other bits stay OFF.
// 2. Domain 3 in RUN, en_req[3]=0, iso_ack[3]=0 for 20 cycles then 1 -> iso held; rsts_n[3]=0 next cycle; clk_en[3]=0 after 8 more cycles.
// 3. en_req[2] pulsed 1 for 2 cycles only -> full power-up to RUN, then power-down sequence; busy[2] high throughout except in RUN.
// 4. All 6 domains enabled in the same cycle, with domain 1 later disabled -> independent timing, no cross-coupling.
// 5. rst_ni asserted mid-CLK_ON and mid-RST -> all outputs return to reset values asynchronously, before the next clk_i edge.
// 6. TIMEOUT_EN with iso_ack held 0 -> RST after 1024 cycles in ISOLATE; timeout_o[d]=1; flag cleared on re-enable into RUN.

Source files
------------

// File: rtl/carfield_domain_sequencer.sv
// Per-domain clock-gate / reset / isolation sequencer, one FSM and counter per domain.
// Optional isolation-ack timeout enabled by defining CARFIELD_DOMAIN_SEQ_TIMEOUT_EN.
module carfield_domain_sequencer #(
  parameter int unsigned NumDomains      = 6,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned RstCycles       = 8,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumDomains-1:0] en_req_i,
  input  logic [NumDomains-1:0] iso_ack_i,
  output logic [NumDomains-1:0] domain_clk_en_o,
  output logic [NumDomains-1:0] domain_rsts_n_o,
  output logic [NumDomains-1:0] domain_iso_o,
  output logic [NumDomains-1:0] domain_on_o,
  output logic [NumDomains-1:0] busy_o,
  output logic [NumDomains-1:0] timeout_o
);

  localparam int unsigned SeqMax = (ClkSettleCycles > RstCycles) ? ClkSettleCycles : RstCycles;
  localparam int unsigned CntMax = (SeqMax > TimeoutCycles) ? SeqMax : TimeoutCycles;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] SettleLast = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstLast    = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
`endif

  typedef enum logic [2:0] {StOff, StClkOn, StRun, StIsolate, StRst} state_e;

  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [4:0]      r_out, w_out;  // {clk_en, rsts_n, iso, on, busy}
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    logic            w_tmo_set;
    logic            r_tmo;
`endif

    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
      w_tmo_set = 1'b0;
`endif
      unique case (r_state)
        StOff: begin
          if (en_req_i[d]) begin
            w_state_d = StClkOn;
            w_cnt_d   = '0;
          end
        end
        StClkOn: begin
          if (r_cnt == SettleLast) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntOne;
          end
        end
        StRun: begin
          if (!en_req_i[d]) begin
            w_state_d = StIsolate;
            w_cnt_d   = '0;
          end
        end
        StIsolate: begin
          // A same-cycle ack beats the timeout, so no flag is raised.
          if (iso_ack_i[d]) begin
            w_state_d = StRst;
            w_cnt_d   = '0;
          end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
          else if (r_cnt == TimeoutLast) begin
            w_state_d = StRst;
            w_cnt_d   = '0;
            w_tmo_set = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntOne;
          end
`endif
        end
        StRst: begin
          if (r_cnt == RstLast) begin
            w_state_d = StOff;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntOne;
          end
        end
        default: begin
          w_state_d = StOff;
          w_cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered, so every pin comes off a flop.
    always_comb begin
      w_out = 5'b00100;
      unique case (w_state_d)
        StOff:     w_out = 5'b00100;
        StClkOn:   w_out = 5'b10101;
        StRun:     w_out = 5'b11010;
        StIsolate: w_out = 5'b11101;
        StRst:     w_out = 5'b10101;
        default:   w_out = 5'b00100;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= StOff;
        r_cnt   <= '0;
        r_out   <= 5'b00100;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
        r_out   <= w_out;
      end
    end

    assign domain_clk_en_o[d] = r_out[4];
    assign domain_rsts_n_o[d] = r_out[3];
    assign domain_iso_o[d]    = r_out[2];
    assign domain_on_o[d]     = r_out[1];
    assign busy_o[d]          = r_out[0];

`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_tmo <= 1'b0;
      end else if (w_tmo_set) begin
        r_tmo <= 1'b1;
      end else if ((w_state_d == StRun) && (r_state != StRun)) begin
        r_tmo <= 1'b0;
      end
    end
    assign timeout_o[d] = r_tmo;
`else
    assign timeout_o[d] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_carfield_domain_sequencer.sv
// Bench for carfield_domain_sequencer: phase table with hand-derived end values plus a
// per-cycle scoreboard fed by a countdown reference model.
module tb_carfield_domain_sequencer;

  localparam int unsigned N       = 6;
  localparam int unsigned Settle  = 4;
  localparam int unsigned RstCyc  = 8;
  localparam int unsigned Timeout = 1024;

  localparam int MOff = 0, MUp = 1, MRun = 2, MIso = 3, MRst = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] en_req_i, iso_ack_i;
  logic [N-1:0] domain_clk_en_o, domain_rsts_n_o, domain_iso_o, domain_on_o, busy_o, timeout_o;

  carfield_domain_sequencer #(
    .NumDomains     (N),
    .ClkSettleCycles(Settle),
    .RstCycles      (RstCyc),
    .TimeoutCycles  (Timeout)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_req_i       (en_req_i),
    .iso_ack_i      (iso_ack_i),
    .domain_clk_en_o(domain_clk_en_o),
    .domain_rsts_n_o(domain_rsts_n_o),
    .domain_iso_o   (domain_iso_o),
    .domain_on_o    (domain_on_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] clk, rst, iso, on, busy, tmo;
  } exp_t;

  typedef struct {
    logic [N-1:0] en, ack;
    int           cyc;
    logic [N-1:0] clk, rst, iso, on, busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[22];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_mode[N];
  int   m_rem[N];
  int   m_tw[N];
  logic m_tf[N];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_mode[d] = MOff;
      m_rem[d]  = 0;
      m_tw[d]   = 0;
      m_tf[d]   = 1'b0;
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic model_edge(input logic [N-1:0] en, input logic [N-1:0] ack);
    for (int d = 0; d < N; d++) begin
      case (m_mode[d])
        MOff: if (en[d]) begin m_mode[d] = MUp; m_rem[d] = Settle; end
        MUp: begin
          m_rem[d]--;
          if (m_rem[d] == 0) begin m_mode[d] = MRun; m_tf[d] = 1'b0; end
        end
        MRun: if (!en[d]) begin m_mode[d] = MIso; m_tw[d] = 0; end
        MIso: begin
          if (ack[d]) begin
            m_mode[d] = MRst; m_rem[d] = RstCyc;
          end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
          else if (m_tw[d] == Timeout - 1) begin
            m_mode[d] = MRst; m_rem[d] = RstCyc; m_tf[d] = 1'b1;
          end else begin
            m_tw[d]++;
          end
`endif
        end
        MRst: begin
          m_rem[d]--;
          if (m_rem[d] == 0) m_mode[d] = MOff;
        end
        default: m_mode[d] = MOff;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.clk[d]  = (m_mode[d] != MOff);
      e.rst[d]  = (m_mode[d] == MRun) || (m_mode[d] == MIso);
      e.iso[d]  = (m_mode[d] != MRun);
      e.on[d]   = (m_mode[d] == MRun);
      e.busy[d] = (m_mode[d] == MUp) || (m_mode[d] == MIso) || (m_mode[d] == MRst);
      e.tmo[d]  = m_tf[d];
    end
    return e;
  endfunction

  // Called just after a negedge: drive, push expectation, let one posedge pass, compare.
  task automatic step(input logic [N-1:0] en, input logic [N-1:0] ack);
    exp_t e;
    en_req_i  = en;
    iso_ack_i = ack;
    model_edge(en, ack);
    sb_q.push_back(model_out());
    @(posedge clk_i);
    @(negedge clk_i);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got no expectation, want one");
    end else begin
      e = sb_q.pop_front();
      check("sb_clk_en", domain_clk_en_o, e.clk);
      check("sb_rsts_n", domain_rsts_n_o, e.rst);
      check("sb_iso", domain_iso_o, e.iso);
      check("sb_on", domain_on_o, e.on);
      check("sb_busy", busy_o, e.busy);
      check("sb_timeout", timeout_o, e.tmo);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk_en"}, domain_clk_en_o, 6'h00);
    check({tag, "_rsts_n"}, domain_rsts_n_o, 6'h00);
    check({tag, "_iso"}, domain_iso_o, 6'h3F);
    check({tag, "_on"}, domain_on_o, 6'h00);
    check({tag, "_busy"}, busy_o, 6'h00);
    check({tag, "_timeout"}, timeout_o, 6'h00);
  endtask

  // Assert reset between clock edges and check the outputs before the next rising edge.
  task automatic async_reset(input string tag);
    #2 rst_ni = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    sb_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          en     ack    cyc  clk    rsts   iso    on     busy
    tbl[0]  = '{6'h00, 6'h3F, 2, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h00};
    tbl[1]  = '{6'h01, 6'h00, 1, 6'h01, 6'h00, 6'h3F, 6'h00, 6'h01};
    tbl[2]  = '{6'h01, 6'h00, 3, 6'h01, 6'h00, 6'h3F, 6'h00, 6'h01};
    tbl[3]  = '{6'h01, 6'h00, 1, 6'h01, 6'h01, 6'h3E, 6'h01, 6'h00};
    tbl[4]  = '{6'h09, 6'h00, 5, 6'h09, 6'h09, 6'h36, 6'h09, 6'h00};
    tbl[5]  = '{6'h01, 6'h00, 20, 6'h09, 6'h09, 6'h3E, 6'h01, 6'h08};
    tbl[6]  = '{6'h01, 6'h08, 1, 6'h09, 6'h01, 6'h3E, 6'h01, 6'h08};
    tbl[7]  = '{6'h01, 6'h08, 7, 6'h09, 6'h01, 6'h3E, 6'h01, 6'h08};
    tbl[8]  = '{6'h01, 6'h08, 1, 6'h01, 6'h01, 6'h3E, 6'h01, 6'h00};
    tbl[9]  = '{6'h05, 6'h00, 2, 6'h05, 6'h01, 6'h3E, 6'h01, 6'h04};
    tbl[10] = '{6'h01, 6'h00, 2, 6'h05, 6'h01, 6'h3E, 6'h01, 6'h04};
    tbl[11] = '{6'h01, 6'h04, 1, 6'h05, 6'h05, 6'h3A, 6'h05, 6'h00};
    tbl[12] = '{6'h01, 6'h04, 1, 6'h05, 6'h05, 6'h3E, 6'h01, 6'h04};
    tbl[13] = '{6'h01, 6'h04, 1, 6'h05, 6'h01, 6'h3E, 6'h01, 6'h04};
    tbl[14] = '{6'h01, 6'h04, 8, 6'h01, 6'h01, 6'h3E, 6'h01, 6'h00};
    tbl[15] = '{6'h3F, 6'h3F, 4, 6'h3F, 6'h01, 6'h3E, 6'h01, 6'h3E};
    tbl[16] = '{6'h3D, 6'h3F, 1, 6'h3F, 6'h3F, 6'h00, 6'h3F, 6'h00};
    tbl[17] = '{6'h3D, 6'h3F, 1, 6'h3F, 6'h3F, 6'h02, 6'h3D, 6'h02};
    tbl[18] = '{6'h3D, 6'h3F, 1, 6'h3F, 6'h3D, 6'h02, 6'h3D, 6'h02};
    tbl[19] = '{6'h3D, 6'h3F, 8, 6'h3D, 6'h3D, 6'h02, 6'h3D, 6'h00};
    tbl[20] = '{6'h00, 6'h3F, 1, 6'h3D, 6'h3D, 6'h3F, 6'h00, 6'h3D};
    tbl[21] = '{6'h00, 6'h3F, 9, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h00};

    rst_ni    = 1'b0;
    en_req_i  = '0;
    iso_ack_i = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_values("por");
    rst_ni = 1'b1;

    for (int i = 0; i < 22; i++) begin
      repeat (tbl[i].cyc) step(tbl[i].en, tbl[i].ack);
      check($sformatf("tbl%0d_clk_en", i), domain_clk_en_o, tbl[i].clk);
      check($sformatf("tbl%0d_rsts_n", i), domain_rsts_n_o, tbl[i].rst);
      check($sformatf("tbl%0d_iso", i), domain_iso_o, tbl[i].iso);
      check($sformatf("tbl%0d_on", i), domain_on_o, tbl[i].on);
      check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
    end

    // Reset in the middle of CLK_ON.
    repeat (2) step(6'h3F, 6'h00);
    check("mid_clkon_busy", busy_o, 6'h3F);
    async_reset("rst_clkon");
    step(6'h00, 6'h00);

    // Reset in the middle of RST.
    repeat (5) step(6'h01, 6'h01);
    repeat (2) step(6'h00, 6'h01);
    repeat (3) step(6'h00, 6'h01);
    check("mid_rst_rsts_n", domain_rsts_n_o, 6'h00);
    check("mid_rst_clk_en", domain_clk_en_o, 6'h01);
    async_reset("rst_rst");
    repeat (2) step(6'h00, 6'h00);

`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    repeat (5) step(6'h10, 6'h00);
    step(6'h00, 6'h00);
    repeat (Timeout - 1) step(6'h00, 6'h00);
    check("tmo_still_iso_busy", busy_o, 6'h10);
    check("tmo_not_yet", timeout_o, 6'h00);
    check("tmo_still_iso_rsts_n", domain_rsts_n_o, 6'h10);
    step(6'h00, 6'h00);
    check("tmo_forced_rst", domain_rsts_n_o, 6'h00);
    check("tmo_flag_set", timeout_o, 6'h10);
    repeat (RstCyc) step(6'h00, 6'h00);
    check("tmo_flag_sticky", timeout_o, 6'h10);
    repeat (Settle + 1) step(6'h10, 6'h00);
    check("tmo_rerun_on", domain_on_o, 6'h10);
    check("tmo_flag_cleared", timeout_o, 6'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
